wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue.sv | 116 +++++++++++
 tb/tb_wb_write_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback queue: funnels mem and ALU results into the single register-file
// write port and forwards queued values to the decode stage.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_valid/mem_reg/mem_data load result in
//   alu_valid/alu_reg/alu_data ALU result in
//   in_ready                  both producers may present this cycle
//   WriteReg/DstReg/DstData   register-file write port (head entry)
//   SrcReg1/SrcReg2           decode-stage read register IDs
//   Hit1/Hit2, FwdData1/2     youngest queued value for each read ID
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [3:0]  mem_reg,
    input  logic [15:0] mem_data,
    input  logic        alu_valid,
    input  logic [3:0]  alu_reg,
    input  logic [15:0] alu_data,
    output logic        in_ready,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    input  logic [3:0]  SrcReg1,
    input  logic [3:0]  SrcReg2,
    output logic        Hit1,
    output logic        Hit2,
    output logic [15:0] FwdData1,
    output logic [15:0] FwdData2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t          ent [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          mem_en;
    logic          alu_en;
    logic [CW-1:0] n_enq;
    logic [PW-1:0] alu_pos;

    // Room for two means both producers can always be taken together.
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign pop      = (count != '0);

    // Writes to r0 are accepted but dropped.
    assign mem_en  = in_ready && mem_valid && (mem_reg != 4'h0);
    assign alu_en  = in_ready && alu_valid && (alu_reg != 4'h0);
    assign n_enq   = CW'(mem_en) + CW'(alu_en);
    // mem is the older of a same-cycle pair, so alu lands behind it.
    assign alu_pos = mem_en ? wptr + PW'(1) : wptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(n_enq);
            rptr  <= rptr + PW'(pop);
            count <= count + n_enq - CW'(pop);
        end
    end

    // Storage is never cleared; count gates every view of it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                ent[wptr] <= '{r: mem_reg, d: mem_data};
            end
            if (alu_en) begin
                ent[alu_pos] <= '{r: alu_reg, d: alu_data};
            end
        end
    end

    assign WriteReg = pop;
    assign DstReg   = pop ? ent[rptr].r : 4'h0;
    assign DstData  = pop ? ent[rptr].d : 16'h0;

    // Walk oldest to youngest so the last match is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        Hit1     = 1'b0;
        Hit2     = 1'b0;
        FwdData1 = 16'h0;
        FwdData2 = 16'h0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if (CW'(i) < count) begin
                if (SrcReg1 != 4'h0 && ent[idx].r == SrcReg1) begin
                    Hit1     = 1'b1;
                    FwdData1 = ent[idx].d;
                end
                if (SrcReg2 != 4'h0 && ent[idx].r == SrcReg2) begin
                    Hit2     = 1'b1;
                    FwdData2 = ent[idx].d;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: a queue of expected entries models the stored
// contents; the write port and forwarding outputs are checked each cycle.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;
    logic        alu_valid;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;
    logic        in_ready;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic        Hit1;
    logic        Hit2;
    logic [15:0] FwdData1;
    logic [15:0] FwdData2;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .in_ready(in_ready),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .Hit1(Hit1), .Hit2(Hit2),
        .FwdData1(FwdData1), .FwdData2(FwdData2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void fwd_model(input logic [3:0] s,
                                      output bit h, output logic [15:0] d);
        h = 0;
        d = 16'h0;
        if (s != 4'h0) begin
            foreach (q[i]) begin
                if (q[i].r == s) begin
                    h = 1;
                    d = q[i].d;
                end
            end
        end
    endfunction

    // Entered just after a falling edge; returns just after the next one.
    task automatic cycle(input bit mv, input logic [3:0] mr,
                         input logic [15:0] md, input bit av,
                         input logic [3:0] ar, input logic [15:0] ad,
                         input logic [3:0] s1, input logic [3:0] s2,
                         output bit acc);
        bit          rdy;
        bit          h;
        logic [15:0] fd;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        SrcReg1 = s1; SrcReg2 = s2;
        #1;
        rdy = (q.size() <= DEPTH - 2);
        check("in_ready", 32'(in_ready), 32'(rdy));
        if (q.size() > 0) begin
            check("WriteReg", 32'(WriteReg), 32'd1);
            check("DstReg", 32'(DstReg), 32'(q[0].r));
            check("DstData", 32'(DstData), 32'(q[0].d));
        end else begin
            check("WriteReg_idle", 32'(WriteReg), 32'd0);
            check("DstReg_idle", 32'(DstReg), 32'd0);
            check("DstData_idle", 32'(DstData), 32'd0);
        end
        fwd_model(s1, h, fd);
        check("Hit1", 32'(Hit1), 32'(h));
        check("FwdData1", 32'(FwdData1), 32'(fd));
        fwd_model(s2, h, fd);
        check("Hit2", 32'(Hit2), 32'(h));
        check("FwdData2", 32'(FwdData2), 32'(fd));
        @(posedge clk);
        if (q.size() > 0) void'(q.pop_front());
        if (rdy) begin
            if (mv && mr != 4'h0) q.push_back('{r: mr, d: md});
            if (av && ar != 4'h0) q.push_back('{r: ar, d: ad});
        end
        acc = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] s1, input logic [3:0] s2);
        bit a;
        cycle(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, s1, s2, a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_valid = 1'b1; mem_reg = 4'h9; mem_data = 16'h5A5A;
        alu_valid = 1'b1; alu_reg = 4'hA; alu_data = 16'hA5A5;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit          acc;
        logic [3:0]  pr_m, pr_a;
        logic [15:0] pd_m, pd_a;
        rst = 1'b1;
        mem_valid = 0; mem_reg = 0; mem_data = 0;
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        SrcReg1 = 0; SrcReg2 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        idle(4'h3, 4'h5);

        // Single write
        cycle(0, 4'h0, 16'h0, 1, 4'h3, 16'h1234, 4'h3, 4'h0, acc);
        check("single_wr", 32'(WriteReg), 32'd1);
        check("single_reg", 32'(DstReg), 32'd3);
        idle(4'h3, 4'h0);
        check("single_done", 32'(WriteReg), 32'd0);
        idle(4'h0, 4'h0);

        // Dual same-cycle write
        cycle(1, 4'h5, 16'hAAAA, 1, 4'h6, 16'hBBBB, 4'h5, 4'h6, acc);
        check("dual_first", 32'(DstReg), 32'd5);
        idle(4'h5, 4'h6);
        check("dual_second", 32'(DstReg), 32'd6);
        idle(4'h5, 4'h6);
        idle(4'h0, 4'h0);

        // Same-register forwarding picks the younger value
        cycle(1, 4'h7, 16'h0001, 1, 4'h7, 16'h0002, 4'h7, 4'h7, acc);
        check("same_fwd", 32'(FwdData1), 32'h0002);
        idle(4'h7, 4'h0);
        check("same_fwd_tail", 32'(FwdData1), 32'h0002);
        idle(4'h7, 4'h0);
        check("same_fwd_gone", 32'(Hit1), 32'd0);

        // Backpressure and pointer wrap with producers holding
        acc = 1;
        pr_m = 0; pr_a = 0; pd_m = 0; pd_a = 0;
        for (int i = 0; i < 20; i++) begin
            if (acc) begin
                pr_m = 4'(1 + (2 * i) % 15);
                pr_a = 4'(1 + (2 * i + 1) % 15);
                pd_m = 16'($urandom);
                pd_a = 16'($urandom);
            end
            cycle(1, pr_m, pd_m, 1, pr_a, pd_a,
                  pr_m, 4'($urandom_range(0, 15)), acc);
        end
        repeat (DEPTH + 1) idle(4'h1, 4'h2);

        // r0 is never stored or forwarded
        cycle(0, 4'h0, 16'h0, 1, 4'h0, 16'hFFFF, 4'h0, 4'h0, acc);
        check("r0_nowr", 32'(WriteReg), 32'd0);
        idle(4'h0, 4'h0);

        // Reset with three entries queued
        cycle(1, 4'h1, 16'h1111, 1, 4'h2, 16'h2222, 4'h1, 4'h2, acc);
        cycle(1, 4'h3, 16'h3333, 1, 4'h4, 16'h4444, 4'h3, 4'h4, acc);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        SrcReg1 = 4'h3; SrcReg2 = 4'h4;
        do_reset();
        idle(4'h3, 4'h4);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_hit1", 32'(Hit1), 32'd0);

        // Random traffic including r0 and holds
        acc = 1;
        for (int i = 0; i < 300; i++) begin
            bit mv, av;
            mv = 1'($urandom);
            av = 1'($urandom);
            if (acc) begin
                pr_m = 4'($urandom);
                pr_a = 4'($urandom);
                pd_m = 16'($urandom);
                pd_a = 16'($urandom);
            end
            cycle(mv, pr_m, pd_m, av, pr_a, pd_a,
                  4'($urandom), 4'($urandom), acc);
            if (i == 150) do_reset();
        end
        repeat (DEPTH + 1) idle(4'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
